// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache, D-cache and shared-memory signals of the arbiter.
// master = arbiter view, slave = cache/memory environment view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);
   logic              i_mem_read;
   logic [ADDR_W-1:0] i_mem_addr;
   logic [DATA_W-1:0] i_mem_rdata;
   logic              i_mem_ready;

   logic              d_mem_read;
   logic              d_mem_write;
   logic [ADDR_W-1:0] d_mem_addr;
   logic [DATA_W-1:0] d_mem_wdata;
   logic [DATA_W-1:0] d_mem_rdata;
   logic              d_mem_ready;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      input  i_mem_read, i_mem_addr,
      input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
      input  mem_rdata, mem_ready,
      output i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      output i_mem_read, i_mem_addr,
      output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
      output mem_rdata, mem_ready,
      input  i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache line fills
// and D-cache allocates/write-backs; one transaction in flight at a time.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic          clk,
   input  logic          proc_reset,
   mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t            state, next_state;
   logic              last_grant;
   logic              owner;
   logic              op_write;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              i_pend, d_pend;
   logic              grant, grant_d;
   logic              busy;

   always_ff @(posedge clk) begin
      if (proc_reset) state <= IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      grant      = 1'b0;
      grant_d    = 1'b0;
      i_pend     = bus.i_mem_read;
      d_pend     = bus.d_mem_read | bus.d_mem_write;
      case (state)
         IDLE: begin
            if (i_pend || d_pend) begin
               grant      = 1'b1;
               // On a tie D wins unless it was granted last.
               grant_d    = d_pend & (~i_pend | (last_grant == OWN_I));
               next_state = BUSY;
            end
         end
         BUSY:    if (bus.mem_ready) next_state = RELEASE;
         RELEASE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         last_grant <= OWN_I;
         owner      <= OWN_I;
         op_write   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         if (grant) begin
            owner    <= grant_d ? OWN_D : OWN_I;
            // Write-back takes priority over allocate when both are asserted.
            op_write <= grant_d & bus.d_mem_write;
            addr_q   <= grant_d ? bus.d_mem_addr : bus.i_mem_addr;
            wdata_q  <= grant_d ? bus.d_mem_wdata : '0;
         end
         if (state == BUSY && bus.mem_ready) last_grant <= owner;
      end
   end

   always_comb begin
      busy            = (state == BUSY) && !proc_reset;
      bus.mem_read    = busy & ~op_write;
      bus.mem_write   = busy & op_write;
      bus.mem_addr    = addr_q;
      bus.mem_wdata   = wdata_q;
      bus.i_mem_ready = busy & bus.mem_ready & (owner == OWN_I);
      bus.d_mem_ready = busy & bus.mem_ready & (owner == OWN_D);
      bus.i_mem_rdata = bus.mem_rdata;
      bus.d_mem_rdata = bus.mem_rdata;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, block address width of every memory port.
REQ-002 Parameter DATA_W, default 128, line width of every memory port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 proc_reset  input  1  reset, synchronous, active-high.
REQ-005 i_mem_read  input  1  I-cache line-fill request.
REQ-006 i_mem_addr  input  ADDR_W  I-cache block address.
REQ-007 i_mem_rdata  output  DATA_W  line returned to I-cache.
REQ-008 i_mem_ready  output  1  I-cache transaction complete strobe.
REQ-009 d_mem_read  input  1  D-cache allocate request.
REQ-010 d_mem_write  input  1  D-cache write-back request.
REQ-011 d_mem_addr  input  ADDR_W  D-cache block address.
REQ-012 d_mem_wdata  input  DATA_W  D-cache write-back line.
REQ-013 d_mem_rdata  output  DATA_W  line returned to D-cache.
REQ-014 d_mem_ready  output  1  D-cache transaction complete strobe.
REQ-015 mem_read, mem_write  output  1 each  strobes to shared memory.
REQ-016 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  shared memory command.
REQ-017 mem_rdata  input  DATA_W; mem_ready  input  1  shared memory response.

Function
REQ-018 FSM states IDLE, BUSY, RELEASE; exactly one state active.
REQ-019 IDLE: requester I pending = i_mem_read; requester D pending = d_mem_read | d_mem_write.
REQ-020 IDLE, exactly one pending: grant it; both pending: grant the one not granted last (round-robin via 1-bit last_grant); none: stay IDLE.
REQ-021 On grant, register grant owner, op (read/write), addr and wdata from the winner; next cycle state = BUSY; I grant forces write = 0, wdata = 0.
REQ-022 D with both d_mem_read and d_mem_write high: latch write only (write-back precedes allocate).
REQ-023 BUSY: mem_read/mem_write/mem_addr/mem_wdata driven from latched registers only; requester input changes ignored.
REQ-024 Latency: request sampled in IDLE at edge N -> mem strobe high from cycle N+1 until mem_ready seen.
REQ-025 BUSY and mem_ready = 1: owner's *_mem_ready = 1 same cycle (combinational); other requester's ready = 0; next state RELEASE; last_grant <= owner.
REQ-026 BUSY and mem_ready = 0: remain BUSY, no timeout.
REQ-027 RELEASE: lasts exactly one cycle, mem_read = mem_write = 0, owner's request ignored (cache holds request one cycle after ready), then IDLE.
REQ-028 RELEASE -> IDLE: other requester pending in IDLE is granted next edge; owner re-requesting is arbitrated normally.
REQ-029 mem_ready outside BUSY: ignored, both *_mem_ready = 0, no state change.
REQ-030 i_mem_rdata = d_mem_rdata = mem_rdata at all times (broadcast); only ready qualifies data.
REQ-031 mem_addr/mem_wdata hold last latched values in IDLE/RELEASE; strobes alone define validity.

Reset
REQ-032 proc_reset high at edge: state <= IDLE, last_grant <= I (D wins first tie), latched op/addr/wdata <= 0.
REQ-033 During and after reset cycle: mem_read = mem_write = 0, i_mem_ready = d_mem_ready = 0.
REQ-034 Reset mid-BUSY aborts transaction; no ready delivered to owner; in-flight mem_ready after reset ignored per REQ-029.

Verification
REQ-035 Single I read addr 0x0000010, mem_ready after 3 cycles, rdata 0xA5..A5 -> mem_read 1 for 4 cycles, i_mem_ready 1 one cycle with i_mem_rdata 0xA5..A5, d_mem_ready 0, mem_read 0 in RELEASE.
REQ-036 After reset, I read and D write (addr 0x0000020, wdata 0x1234..) same cycle -> D granted first (mem_write 1, mem_addr 0x0000020), I granted immediately after RELEASE.
REQ-037 Both continuously requesting for 4 transactions -> grants alternate D, I, D, I; each ready routed to correct owner only.
REQ-038 D changes d_mem_addr from 0x5 to 0x9 during BUSY -> mem_addr stays 0x5 until ready; D asserting read and write together -> mem_write 1, mem_read 0.
REQ-039 proc_reset asserted during BUSY, mem_ready pulses next cycle -> no *_mem_ready, state IDLE, strobes 0.
REQ-040 mem_ready pulsed in IDLE with no request -> both ready outputs 0, no grant issued.
